// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream signal bundle for the pattern generator: master drives data and sideband,
// slave returns tready.
interface axis_pattern_gen_if #(
  parameter int unsigned TDATA_SIZE = 32
);
  logic [TDATA_SIZE-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream traffic source: packets of programmable length/count/gap carrying an incrementing,
// LFSR, constant or walking-one pattern that advances once per accepted beat.
module axis_pattern_gen #(
  parameter int unsigned TDATA_SIZE = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter logic [63:0] LFSR_SEED  = 64'hACE1_2468,
  parameter logic [63:0] CONST_WORD = 64'hA5A5_A5A5
) (
  input  logic                 m_axis_aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [LEN_WIDTH-1:0] pkt_count,
  input  logic [LEN_WIDTH-1:0] idle_cycles,
  axis_pattern_gen_if.master   m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          beat_count
);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;
  typedef enum logic [1:0] {ModeInc, ModeLfsr, ModeConst, ModeWalk} mode_e;

  localparam logic [63:0]            TapsFull  = 64'h8020_0003;
  localparam logic [TDATA_SIZE-1:0]  TopBit    = {1'b1, {(TDATA_SIZE-1){1'b0}}};
  // Feedback always reaches the MSB so narrow widths still form a closed register.
  localparam logic [TDATA_SIZE-1:0]  LfsrTaps  = TapsFull[TDATA_SIZE-1:0] | TopBit;
  localparam logic [TDATA_SIZE-1:0]  SeedRaw   = LFSR_SEED[TDATA_SIZE-1:0];
  localparam logic [TDATA_SIZE-1:0]  LfsrInit  = (SeedRaw == '0) ? TDATA_SIZE'(1) : SeedRaw;
  localparam logic [TDATA_SIZE-1:0]  ConstFill = CONST_WORD[TDATA_SIZE-1:0];
  localparam logic [LEN_WIDTH-1:0]   LenOne    = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  idle_q, idle_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  pkt_q, pkt_d;
  logic [LEN_WIDTH-1:0]  gap_q, gap_d;
  logic [TDATA_SIZE-1:0] data_q, data_d;
  logic [31:0]           beat_count_q, beat_count_d;

  logic send;
  logic zero_run;
  logic last_beat;
  logic last_pkt;
  logic gap_end;

  function automatic logic [TDATA_SIZE-1:0] pattern_init(input mode_e m);
    logic [TDATA_SIZE-1:0] v;
    case (m)
      ModeInc:   v = '0;
      ModeLfsr:  v = LfsrInit;
      ModeConst: v = ConstFill;
      ModeWalk:  v = TDATA_SIZE'(1);
      default:   v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [TDATA_SIZE-1:0] pattern_next(input mode_e m,
                                                          input logic [TDATA_SIZE-1:0] cur);
    logic [TDATA_SIZE-1:0] v;
    case (m)
      ModeInc:   v = cur + TDATA_SIZE'(1);
      ModeLfsr:  v = {1'b0, cur[TDATA_SIZE-1:1]} ^ (cur[0] ? LfsrTaps : '0);
      ModeConst: v = cur;
      ModeWalk:  v = {cur[TDATA_SIZE-2:0], cur[TDATA_SIZE-1]};
      default:   v = cur;
    endcase
    return v;
  endfunction

  assign send      = (state_q == StSend);
  assign zero_run  = (pkt_len == '0) || (pkt_count == '0);
  assign last_beat = (beat_q == len_q - LenOne);
  assign last_pkt  = (pkt_q == cnt_q - LenOne);
  assign gap_end   = (gap_q == idle_q - LenOne);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    beat_d       = beat_q;
    pkt_d        = pkt_q;
    gap_d        = gap_q;
    data_d       = data_q;
    beat_count_d = beat_count_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mode_d       = mode_e'(mode);
          len_d        = pkt_len;
          cnt_d        = pkt_count;
          idle_d       = idle_cycles;
          beat_d       = '0;
          pkt_d        = '0;
          gap_d        = '0;
          beat_count_d = '0;
          data_d       = pattern_init(mode_e'(mode));
          state_d      = zero_run ? StDone : StSend;
        end
      end
      StSend: begin
        if (m_axis.tready) begin
          beat_count_d = beat_count_q + 32'd1;
          data_d       = pattern_next(mode_q, data_q);
          if (last_beat) begin
            beat_d = '0;
            if (last_pkt) begin
              state_d = StDone;
            end else begin
              pkt_d   = pkt_q + LenOne;
              gap_d   = '0;
              state_d = (idle_q == '0) ? StSend : StGap;
            end
          end else begin
            beat_d = beat_q + LenOne;
          end
        end
      end
      StGap: begin
        if (gap_end) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q + LenOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      mode_q       <= ModeInc;
      len_q        <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      beat_q       <= '0;
      pkt_q        <= '0;
      gap_q        <= '0;
      data_q       <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      beat_q       <= beat_d;
      pkt_q        <= pkt_d;
      gap_q        <= gap_d;
      data_q       <= data_d;
      beat_count_q <= beat_count_d;
    end
  end

  // All stream outputs come straight from state, so tvalid never sees tready combinationally.
  assign m_axis.tvalid = send;
  assign m_axis.tdata  = data_q;
  assign m_axis.tuser  = send && (beat_q == '0);
  assign m_axis.tlast  = send && last_beat;

  assign busy       = (state_q == StSend) || (state_q == StGap);
  assign done       = (state_q == StDone);
  assign beat_count = beat_count_q;

`ifndef SYNTHESIS
  stall_hold_a: assert property (@(posedge m_axis_aclk) disable iff (!aresetn)
    (m_axis.tvalid && !m_axis.tready) |=>
      (m_axis.tvalid && $stable({m_axis.tdata, m_axis.tlast, m_axis.tuser})));
`endif

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Scoreboard bench for axis_pattern_gen: runs push expected beats from a pattern model, a
// negedge monitor pops and compares every accepted beat, gap length and stall stability.
module tb_axis_pattern_gen;

  localparam int W  = 32;
  localparam int LW = 16;
  localparam logic [31:0] Seed  = 32'hACE1_2468;
  localparam logic [31:0] Fill  = 32'hA5A5_A5A5;
  localparam logic [31:0] Poly  = 32'h8020_0003;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    int          gap;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [LW-1:0] pkt_len = '0;
  logic [LW-1:0] pkt_count = '0;
  logic [LW-1:0] idle_cycles = '0;
  logic          busy;
  logic          done;
  logic [31:0]   beat_count;

  axis_pattern_gen_if #(.TDATA_SIZE(W)) m_axis ();

  axis_pattern_gen #(
    .TDATA_SIZE(W),
    .LEN_WIDTH (LW)
  ) dut (
    .m_axis_aclk(clk),
    .aresetn    (rst_n),
    .start      (start),
    .mode       (mode),
    .pkt_len    (pkt_len),
    .pkt_count  (pkt_count),
    .idle_cycles(idle_cycles),
    .m_axis     (m_axis),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 held low
  beat_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Galois step: divide by x modulo x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ Poly) : (s >> 1);
  endfunction

  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = ~m_axis.tready;
        2:       m_axis.tready = 1'($urandom_range(0, 1));
        default: m_axis.tready = 1'b0;
      endcase
    end
  end

  // Monitor
  int          low_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;
  beat_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_axis.tvalid), 64'd1);
        check("stall_hold", 64'({m_axis.tdata, m_axis.tlast, m_axis.tuser}), 64'(prev_word));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h expected no beat at %0t",
                   m_axis.tdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("tdata", 64'(m_axis.tdata), 64'(e.data));
          check("tlast", 64'(m_axis.tlast), 64'(e.last));
          check("tuser", 64'(m_axis.tuser), 64'(e.user));
          if (e.gap >= 0) check("gap_len", 64'(low_cnt), 64'(e.gap));
        end
        low_cnt = 0;
      end else if (!m_axis.tvalid) begin
        low_cnt++;
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_word  = {m_axis.tdata, m_axis.tlast, m_axis.tuser};
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    mode        = 2'($urandom);
    pkt_len     = LW'($urandom_range(0, 40));
    pkt_count   = LW'($urandom_range(0, 5));
    idle_cycles = LW'($urandom_range(0, 9));
  endtask

  task automatic do_run(input int md, input int len, input int cnt, input int idle,
                        input int rdy, input bit inject);
    int          n;
    int          k;
    logic [31:0] lf;
    beat_t       b;
    n  = 0;
    lf = Seed;
    for (int p = 0; p < cnt; p++) begin
      for (int i = 0; i < len; i++) begin
        case (md)
          0:       b.data = 32'(n);
          1:       b.data = lf;
          2:       b.data = Fill;
          default: b.data = 32'h1 << (n % W);
        endcase
        b.last = (i == len - 1);
        b.user = (i == 0);
        b.gap  = (p > 0 && i == 0) ? idle : -1;
        exp_q.push_back(b);
        n++;
        lf = lfsr_step(lf);
      end
    end
    rdy_mode    = rdy;
    mode        = 2'(md);
    pkt_len     = LW'(len);
    pkt_count   = LW'(cnt);
    idle_cycles = LW'(idle);
    pulse_start();
    @(negedge clk);
    if (len > 0 && cnt > 0) begin
      check("first_valid", 64'(m_axis.tvalid), 64'd1);
      check("busy_on", 64'(busy), 64'd1);
      check("done_clr", 64'(done), 64'd0);
    end else begin
      check("zero_done", 64'(done), 64'd1);
      check("zero_valid", 64'(m_axis.tvalid), 64'd0);
      check("zero_busy", 64'(busy), 64'd0);
    end
    if (inject) begin
      @(posedge clk);
      #1;
      mode        = 2'd2;
      pkt_len     = LW'(1);
      pkt_count   = LW'(1);
      idle_cycles = '0;
      pulse_start();
    end
    k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("beat_count", 64'(beat_count), 64'(len * cnt));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("busy_off", 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected run completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(m_axis.tvalid), 64'd0);
    check("rst_out", 64'({m_axis.tdata, m_axis.tlast, m_axis.tuser}), 64'd0);
    check("rst_status", 64'({busy, done, beat_count}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(0, 4, 2, 0, 0, 1'b0);   // incrementing, back-to-back packets
    do_run(2, 3, 1, 0, 1, 1'b0);   // constant with toggling ready
    do_run(3, 33, 1, 0, 0, 1'b0);  // walking one wraps past the top bit
    do_run(1, 2, 3, 5, 0, 1'b0);   // LFSR continues across gapped packets
    do_run(0, 0, 3, 0, 0, 1'b0);   // zero length
    do_run(1, 4, 0, 2, 0, 1'b0);   // zero count
    do_run(0, 5, 2, 2, 0, 1'b1);   // start while busy must be ignored

    for (int r = 0; r < 10; r++) begin
      do_run($urandom_range(0, 3), $urandom_range(1, 7), $urandom_range(1, 4),
             $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    // Asynchronous reset mid-beat while stalled
    rdy_mode    = 3;
    mode        = 2'd0;
    pkt_len     = LW'(4);
    pkt_count   = LW'(1);
    idle_cycles = '0;
    pulse_start();
    @(negedge clk);
    check("pre_rst_valid", 64'(m_axis.tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(m_axis.tvalid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(m_axis.tvalid), 64'd0);
    check("post_rst_status", 64'({busy, done, beat_count}), 64'd0);

    do_run(3, 6, 2, 1, 2, 1'b0);   // recovery from IDLE after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
